// File: rtl/hawk_axird_pkg.sv
// Packet types exchanged between hawk_pgrd_mngr and the AXI4 read initiator.
// Widths follow the HACD AXI4 configuration used across the hawk blocks.
package hawk_axird_pkg;

   localparam int HACD_AXI4_ADDR_WIDTH = 64;
   localparam int HACD_AXI4_DATA_WIDTH = 512;
   localparam int HACD_AXI4_LEN_WIDTH  = 8;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
      logic [HACD_AXI4_LEN_WIDTH-1:0]  arlen;
      logic                            arvalid;
      logic                            rready;
   } axi_rd_reqpkt_t;

   typedef struct packed {
      logic arready;
   } axi_rd_rdypkt_t;

   typedef struct packed {
      logic [1:0]                      rresp;
      logic [HACD_AXI4_DATA_WIDTH-1:0] rdata;
      logic                            rvalid;
      logic                            rlast;
   } axi_rd_resppkt_t;

endpackage

// File: rtl/hawk_axird_master_if.sv
// AXI4 read-address and read-data channels between the read initiator and
// the DDR-side interconnect.
interface hawk_axird_master_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512,
   parameter int LEN_WIDTH  = 8,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [LEN_WIDTH-1:0]  arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/hawk_axird_master.sv
// AXI4 read initiator: issues one INCR burst per manager request and streams
// the R beats back through a one-entry output register, flagging protocol errors.
module hawk_axird_master
   import hawk_axird_pkg::*;
#(
   parameter int          ADDR_WIDTH = 64,
   parameter int          DATA_WIDTH = 512,
   parameter int          LEN_WIDTH  = 8,
   parameter int          ID_WIDTH   = 4,
   parameter int unsigned AXI_ID     = 0,
   parameter bit          SWAP_EN    = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  axi_rd_reqpkt_t       rd_reqpkt_i,
   output axi_rd_rdypkt_t       rd_rdypkt_o,
   output axi_rd_resppkt_t      rd_resppkt_o,
   output logic                 proto_err_o,
   hawk_axird_master_if.master  m_axi
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      AR_SEND = 2'd1,
      R_WAIT  = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH:0]    cnt_r;
   logic                  out_valid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;
   logic                  rlast_r;
   logic                  proto_err_r;
   logic                  capture_s;
   logic                  beat_s;
   logic                  arready_s;
   logic                  arvalid_s;
   logic                  rready_s;
   logic                  err_s;
   logic [DATA_WIDTH-1:0] swap_data_s;

   // Reverse the byte order inside every 64-bit lane of a beat.
   function automatic logic [DATA_WIDTH-1:0] get_8byte_byteswap(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] s;
      s = {DATA_WIDTH{1'b0}};
      for (int ln = 0; ln < DATA_WIDTH / 64; ln++) begin
         for (int bt = 0; bt < 8; bt++) begin
            s[ln*64 + bt*8 +: 8] = d[ln*64 + (7 - bt)*8 +: 8];
         end
      end
      return s;
   endfunction

   assign swap_data_s = SWAP_EN ? get_8byte_byteswap(m_axi.rdata) : m_axi.rdata;

   // Next-state and handshake decode.
   always_comb begin
      state_s   = state_r;
      capture_s = 1'b0;
      beat_s    = 1'b0;
      arready_s = 1'b0;
      arvalid_s = 1'b0;
      rready_s  = 1'b0;
      case (state_r)
         IDLE: begin
            arready_s = 1'b1;
            if (rd_reqpkt_i.arvalid) begin
               capture_s = 1'b1;
               state_s   = AR_SEND;
            end else begin
               state_s   = IDLE;
            end
         end
         AR_SEND: begin
            arvalid_s = 1'b1;
            if (m_axi.arready) begin
               state_s = R_WAIT;
            end else begin
               state_s = AR_SEND;
            end
         end
         R_WAIT: begin
            // Output register drains and reloads in the same cycle.
            rready_s = !out_valid_r || rd_reqpkt_i.rready;
            if (rready_s && m_axi.rvalid) begin
               beat_s  = 1'b1;
               state_s = m_axi.rlast ? IDLE : R_WAIT;
            end else begin
               state_s = R_WAIT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Protocol check: a beat past arlen without rlast keeps flagging until rlast.
   always_comb begin
      err_s = 1'b0;
      if (m_axi.rid != ID_WIDTH'(AXI_ID)) begin
         err_s = 1'b1;
      end else if (m_axi.rlast) begin
         err_s = (cnt_r != {1'b0, len_r});
      end else begin
         err_s = (cnt_r >= {1'b0, len_r});
      end
   end

   // State, captured request, beat counter and response register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         addr_r      <= {ADDR_WIDTH{1'b0}};
         len_r       <= {LEN_WIDTH{1'b0}};
         cnt_r       <= {(LEN_WIDTH+1){1'b0}};
         out_valid_r <= 1'b0;
         rdata_r     <= {DATA_WIDTH{1'b0}};
         rresp_r     <= 2'b00;
         rlast_r     <= 1'b0;
         proto_err_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         proto_err_r <= beat_s && err_s;
         if (capture_s) begin
            addr_r <= rd_reqpkt_i.addr;
            len_r  <= rd_reqpkt_i.arlen;
            cnt_r  <= {(LEN_WIDTH+1){1'b0}};
         end else if (beat_s && (cnt_r != {(LEN_WIDTH+1){1'b1}})) begin
            cnt_r  <= cnt_r + (LEN_WIDTH+1)'(1);
         end else begin
            cnt_r  <= cnt_r;
         end
         if (beat_s) begin
            out_valid_r <= 1'b1;
            rdata_r     <= swap_data_s;
            rresp_r     <= m_axi.rresp;
            rlast_r     <= m_axi.rlast;
         end else if (rd_reqpkt_i.rready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign m_axi.arid    = ID_WIDTH'(AXI_ID);
   assign m_axi.araddr  = addr_r;
   assign m_axi.arlen   = len_r;
   assign m_axi.arsize  = 3'b110;
   assign m_axi.arburst = 2'b01;
   assign m_axi.arvalid = arvalid_s;
   assign m_axi.rready  = rready_s;

   assign rd_rdypkt_o  = '{arready: arready_s};
   assign rd_resppkt_o = '{rresp: rresp_r, rdata: rdata_r, rvalid: out_valid_r, rlast: rlast_r};
   assign proto_err_o  = proto_err_r;

endmodule

// File: tb/tb_hawk_axird_master.sv
// Directed bench for hawk_axird_master: AR issue, beat streaming with byteswap,
// backpressure, protocol-error pulses and reset mid-burst, scoreboard-checked.
module tb_hawk_axird_master;
   import hawk_axird_pkg::*;

   typedef struct {
      logic [511:0] data;
      logic         last;
      logic [1:0]   resp;
   } sb_t;

   logic            clk;
   logic            rst_ni;
   axi_rd_reqpkt_t  rd_req;
   axi_rd_rdypkt_t  rd_rdy;
   axi_rd_resppkt_t rd_resp;
   logic            proto_err;
   sb_t             sb[$];
   sb_t             mon_e;
   int              errors = 0;
   int              checks = 0;
   int              delivered = 0;
   int              perr_cnt = 0;
   int              d0;
   int              p0;

   hawk_axird_master_if m_axi_if ();

   hawk_axird_master dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .rd_reqpkt_i  (rd_req),
      .rd_rdypkt_o  (rd_rdy),
      .rd_resppkt_o (rd_resp),
      .proto_err_o  (proto_err),
      .m_axi        (m_axi_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Byte k of the result comes from byte (k with its low 3 bits inverted).
   function automatic logic [511:0] swap_model(input logic [511:0] d);
      logic [511:0] o;
      for (int k = 0; k < 64; k++) o[8*k +: 8] = d[8*(k ^ 7) +: 8];
      return o;
   endfunction

   function automatic logic [511:0] pat(input logic [7:0] base);
      logic [511:0] p;
      for (int k = 0; k < 64; k++) p[8*k +: 8] = base + 8'(k);
      return p;
   endfunction

   task automatic do_req(input logic [63:0] a, input logic [7:0] l, input int stall);
      chk("idle_arready", 512'(rd_rdy.arready), 512'd1);
      rd_req.addr    = a;
      rd_req.arlen   = l;
      rd_req.arvalid = 1'b1;
      tick();
      rd_req.arvalid = 1'b0;
      rd_req.addr    = 64'hDEAD_BEEF_DEAD_BEEF;
      rd_req.arlen   = 8'hA5;
      chk("ar_valid", 512'(m_axi_if.arvalid), 512'd1);
      chk("ar_addr", 512'(m_axi_if.araddr), 512'(a));
      chk("ar_len", 512'(m_axi_if.arlen), 512'(l));
      chk("ar_size", 512'(m_axi_if.arsize), 512'd6);
      chk("ar_burst", 512'(m_axi_if.arburst), 512'd1);
      chk("ar_id", 512'(m_axi_if.arid), 512'd0);
      chk("busy_arready", 512'(rd_rdy.arready), 512'd0);
      for (int i = 0; i < stall; i++) begin
         tick();
         chk("stall_arvalid", 512'(m_axi_if.arvalid), 512'd1);
         chk("stall_addr", 512'(m_axi_if.araddr), 512'(a));
         chk("stall_len", 512'(m_axi_if.arlen), 512'(l));
      end
      m_axi_if.arready = 1'b1;
      tick();
      m_axi_if.arready = 1'b0;
      chk("ar_done", 512'(m_axi_if.arvalid), 512'd0);
   endtask

   task automatic send_beat(input logic [511:0] d, input logic last, input logic [3:0] id,
                            input logic [1:0] resp);
      int n;
      sb_t e;
      m_axi_if.rdata  = d;
      m_axi_if.rlast  = last;
      m_axi_if.rid    = id;
      m_axi_if.rresp  = resp;
      m_axi_if.rvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!m_axi_if.rready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("r_accept_timeout", 512'(n < 50), 512'd1);
      e.data = swap_model(d);
      e.last = last;
      e.resp = resp;
      sb.push_back(e);
      @(posedge clk);
      #1;
      m_axi_if.rvalid = 1'b0;
      m_axi_if.rlast  = 1'b0;
   endtask

   // Manager side: every delivered beat must match the head of the scoreboard.
   always @(negedge clk) begin
      if (proto_err) perr_cnt++;
      if (rd_resp.rvalid && rd_req.rready) begin
         delivered++;
         chk("beat_expected", 512'(sb.size() != 0), 512'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("beat_data", rd_resp.rdata, mon_e.data);
            chk("beat_last", 512'(rd_resp.rlast), 512'(mon_e.last));
            chk("beat_resp", 512'(rd_resp.rresp), 512'(mon_e.resp));
         end
      end
   end

   initial begin
      rst_ni = 1'b0;
      rd_req = '0;
      rd_req.rready     = 1'b1;
      m_axi_if.arready  = 1'b0;
      m_axi_if.rvalid   = 1'b0;
      m_axi_if.rlast    = 1'b0;
      m_axi_if.rid      = 4'd0;
      m_axi_if.rresp    = 2'b00;
      m_axi_if.rdata    = '0;
      #2;
      chk("rst_arready", 512'(rd_rdy.arready), 512'd1);
      chk("rst_arvalid", 512'(m_axi_if.arvalid), 512'd0);
      chk("rst_rready", 512'(m_axi_if.rready), 512'd0);
      chk("rst_araddr", 512'(m_axi_if.araddr), 512'd0);
      chk("rst_resp", 512'({rd_resp.rresp, rd_resp.rvalid, rd_resp.rlast}), 512'd0);
      chk("rst_perr", 512'(proto_err), 512'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();

      // Single beat, immediate AR ready.
      p0 = perr_cnt;
      do_req(64'h0000_00FF_F610_0040, 8'd0, 0);
      send_beat(pat(8'h00), 1'b1, 4'd0, 2'b00);
      chk("single_rvalid", 512'(rd_resp.rvalid), 512'd1);
      chk("single_rlast", 512'(rd_resp.rlast), 512'd1);
      chk("single_lane0", 512'(rd_resp.rdata[63:0]), 512'(64'h0001020304050607));
      chk("single_arready", 512'(rd_rdy.arready), 512'd1);
      tick();
      chk("single_perr", 512'(perr_cnt - p0), 512'd0);

      // Four-beat burst with AR stall, streamed back to back.
      p0 = perr_cnt;
      d0 = delivered;
      do_req(64'h0000_0000_1234_5000, 8'd3, 5);
      for (int i = 0; i < 4; i++) send_beat(pat(8'(8'h10 + 8'(16*i))), (i == 3), 4'd0, 2'(i));
      tick();
      tick();
      chk("burst4_count", 512'(delivered - d0), 512'd4);
      chk("burst4_sb_empty", 512'(sb.size()), 512'd0);
      chk("burst4_perr", 512'(perr_cnt - p0), 512'd0);

      // Manager backpressure for three cycles mid-burst.
      d0 = delivered;
      do_req(64'h0000_0000_0000_8000, 8'd3, 0);
      send_beat(pat(8'h80), 1'b0, 4'd0, 2'b00);
      rd_req.rready   = 1'b0;
      m_axi_if.rdata  = pat(8'h90);
      m_axi_if.rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_rready_low", 512'(m_axi_if.rready), 512'd0);
         chk("bp_hold_valid", 512'(rd_resp.rvalid), 512'd1);
         tick();
      end
      rd_req.rready = 1'b1;
      send_beat(pat(8'h90), 1'b0, 4'd0, 2'b00);
      send_beat(pat(8'hA0), 1'b0, 4'd0, 2'b00);
      send_beat(pat(8'hB0), 1'b1, 4'd0, 2'b00);
      tick();
      tick();
      chk("bp_count", 512'(delivered - d0), 512'd4);
      chk("bp_sb_empty", 512'(sb.size()), 512'd0);

      // Early rlast on beat 2 of arlen=3.
      p0 = perr_cnt;
      d0 = delivered;
      do_req(64'h0000_0000_0000_C000, 8'd3, 0);
      send_beat(pat(8'h20), 1'b0, 4'd0, 2'b00);
      send_beat(pat(8'h30), 1'b1, 4'd0, 2'b00);
      chk("early_arready", 512'(rd_rdy.arready), 512'd1);
      tick();
      chk("early_perr", 512'(perr_cnt - p0), 512'd1);
      chk("early_count", 512'(delivered - d0), 512'd2);

      // Wrong rid on one beat: single pulse, data still delivered.
      p0 = perr_cnt;
      d0 = delivered;
      do_req(64'h0000_0000_0000_D000, 8'd1, 0);
      send_beat(pat(8'h40), 1'b0, 4'd1, 2'b00);
      send_beat(pat(8'h50), 1'b1, 4'd0, 2'b00);
      tick();
      chk("rid_perr", 512'(perr_cnt - p0), 512'd1);
      chk("rid_count", 512'(delivered - d0), 512'd2);

      // Missing rlast: arlen=1 but rlast arrives on the third beat.
      p0 = perr_cnt;
      d0 = delivered;
      do_req(64'h0000_0000_0000_E000, 8'd1, 0);
      send_beat(pat(8'h60), 1'b0, 4'd0, 2'b00);
      send_beat(pat(8'h70), 1'b0, 4'd0, 2'b00);
      chk("late_still_busy", 512'(rd_rdy.arready), 512'd0);
      send_beat(pat(8'hC0), 1'b1, 4'd0, 2'b00);
      tick();
      chk("late_perr", 512'(perr_cnt - p0), 512'd2);
      chk("late_count", 512'(delivered - d0), 512'd3);

      // Reset after beat 1 of arlen=3 with that beat still held.
      do_req(64'h0000_0000_0000_F000, 8'd3, 0);
      send_beat(pat(8'hD0), 1'b0, 4'd0, 2'b01);
      rd_req.rready = 1'b0;
      rst_ni = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_rvalid", 512'(rd_resp.rvalid), 512'd0);
      chk("mid_rst_rdata", rd_resp.rdata, 512'd0);
      chk("mid_rst_rresp", 512'(rd_resp.rresp), 512'd0);
      chk("mid_rst_arready", 512'(rd_rdy.arready), 512'd1);
      chk("mid_rst_rready", 512'(m_axi_if.rready), 512'd0);
      chk("mid_rst_araddr", 512'(m_axi_if.araddr), 512'd0);
      chk("mid_rst_arlen", 512'(m_axi_if.arlen), 512'd0);
      tick();
      rst_ni = 1'b1;
      rd_req.rready = 1'b1;
      tick();
      chk("post_rst_arready", 512'(rd_rdy.arready), 512'd1);
      chk("post_rst_arvalid", 512'(m_axi_if.arvalid), 512'd0);
      chk("post_rst_rvalid", 512'(rd_resp.rvalid), 512'd0);

      // Recovery: a fresh single-beat burst after reset.
      d0 = delivered;
      do_req(64'h0000_0000_0001_0000, 8'd0, 1);
      send_beat(pat(8'hE0), 1'b1, 4'd0, 2'b00);
      tick();
      tick();
      chk("recover_count", 512'(delivered - d0), 512'd1);
      chk("final_sb_empty", 512'(sb.size()), 512'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hawk_axird_master.md
# hawk_axird_master

AXI4 read initiator between `hawk_pgrd_mngr` and the DDR-side AXI4 interconnect. It accepts one read-burst request packet (`axi_rd_reqpkt_t`: addr, arlen, arvalid, rready) and drives the AR channel. It returns each R beat to the manager as an `axi_rd_resppkt_t`, with optional 8-byte byteswap applied to the data. It is the read-direction counterpart of `hawk_axiwr_master` and keeps one burst outstanding at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, default 64: AXI address width (`HACD_AXI4_ADDR_WIDTH`).
- `DATA_WIDTH`, default 512: AXI data width, one 64 B cache line per beat.
- `LEN_WIDTH`, default 8: arlen width (`HACD_AXI4_LEN_WIDTH`).
- `ID_WIDTH`, default 4: AXI ID width.
- `AXI_ID`, default 0: fixed arid; rid is checked against it.
- `SWAP_EN`, default 1: when 1, the block applies `get_8byte_byteswap` to rdata before returning it.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `rd_reqpkt_i`, in, `axi_rd_reqpkt_t`: request addr/arlen/arvalid, plus rready for the response path.
- `rd_rdypkt_o`, out, `axi_rd_rdypkt_t`: arready back to the manager.
- `rd_resppkt_o`, out, `axi_rd_resppkt_t`: rresp/rdata/rvalid/rlast to the manager.
- `proto_err_o`, out, 1: one-cycle pulse on an R-channel protocol violation.
- `m_axi_arid`/`araddr`/`arlen`, out, ID/ADDR/LEN: AR payload.
- `m_axi_arsize`, out, 3: AR size.
- `m_axi_arburst`, out, 2: AR burst type.
- `m_axi_arvalid`, out, 1: AR valid.
- `m_axi_arready`, in, 1: AR ready.
- `m_axi_rid`/`rdata`/`rresp`/`rlast`/`rvalid`, in: R channel.
- `m_axi_rready`, out, 1: R ready.

## Operation
- FSM states: IDLE, AR_SEND, R_WAIT.
- IDLE: `rd_rdypkt_o.arready`=1. When arvalid=1, the block captures addr and arlen into registers, clears the beat counter, and moves to AR_SEND.
- AR_SEND: `m_axi_arvalid`=1 with the captured payload held stable. On the cycle with arvalid & arready, the FSM moves to R_WAIT.
- Fixed AR fields: arsize=3'b110; arburst=2'b01 (INCR); arid=AXI_ID.
- R_WAIT: each accepted beat (rvalid & rready) loads the output register and increments the beat counter (LEN_WIDTH+1 bits).
- The burst ends on the beat with `m_axi_rlast`=1; the FSM then returns to IDLE in the same cycle.
- Output register: `m_axi_rready` = (state==R_WAIT) & (!out_valid_q | rd_reqpkt_i.rready). This is a one-entry pipeline, so a full register drains and reloads in the same cycle.
- Output rdata = SWAP_EN ? byteswap(m_axi_rdata) : m_axi_rdata. rresp and rlast pass through registered.
- `proto_err_o` pulses on an accepted beat when either of these holds:
  - rid != AXI_ID;
  - the rlast position disagrees with the count: rlast with count != arlen, or no rlast with count == arlen.
- On an early rlast, the burst terminates anyway. On a missing rlast, the block keeps accepting beats until rlast arrives, pulsing `proto_err_o` once per extra beat.
- Response data is never dropped or reordered.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, so arready=1 (requests are not captured while `rst_ni`=0);
  - `m_axi_arvalid`=0, `m_axi_rready`=0;
  - araddr=0, arlen=0, arid=AXI_ID, arsize=3'b110, arburst=2'b01;
  - rd_resppkt_o all-zero (rvalid=0);
  - `proto_err_o`=0.
- Request capture in cycle N: `m_axi_arvalid`=1 in N+1. arready in IDLE is combinational from state.
- An R beat accepted in cycle M appears with rd_resppkt_o.rvalid=1 in M+1. It holds until rready=1.
- Back-to-back beats stream at one per cycle while the manager holds rready=1.
- Last beat accepted in cycle L: arready=1 in L+1. A new request can be captured while the last beat still sits in the output register.
- Reset mid-burst: the FSM returns to IDLE immediately and the pending output beat is discarded. The interconnect is reset together with this block.

## Test plan
- Single beat: req addr=0xFFF6100040, arlen=0, with AR ready immediately. Expect arvalid in cycle 1, araddr=0xFFF6100040, arlen=0, arsize=6, arburst=1. The R beat (rdata bytes 0x00..0x3F, rlast=1) returns one cycle later as rvalid/rlast=1 with each 8-byte lane byte-reversed (lane0 = 0x0001020304050607). arready=1 the cycle after.
- 4-beat burst, arlen=3, with `m_axi_arready` held low 5 cycles. Expect araddr/arlen stable during the stall and 4 output beats in order, rlast only on the 4th. `proto_err_o` stays 0.
- Backpressure: manager rready=0 for 3 cycles mid-burst. Expect `m_axi_rready`=0 while the register is full, no beat lost or duplicated, and the beat sequence unchanged.
- Early rlast: arlen=3 with rlast on beat 2. Expect `proto_err_o` pulse on beat 2, 2 beats delivered, FSM back to IDLE.
- Wrong rid: rid=AXI_ID+1 on one beat. Expect one `proto_err_o` pulse and the data still delivered.
- Reset mid-burst: drop `rst_ni` after beat 1 of arlen=3. Expect all outputs at reset values and arready=1 after release.
